// File: rtl/wb_regfile.sv
// Writeback-stage register file: 32 x 32-bit registers with r0 hardwired to
// zero, same-cycle write-to-read bypass on the rs, rt and debug read ports,
// a sticky halt flag and a saturating retired-instruction counter.
module wb_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_mem_wb,
   input  logic [31:0] instruction_mem_wb,
   input  logic        MemtoReg_mem_wb,
   input  logic [1:0]  Jump_mem_wb,
   input  logic [31:0] alu_out_mem_wb,
   input  logic [31:0] ram_read_data_mem_wb,
   input  logic        RegWrite_mem_wb,
   input  logic        halt_mem_wb,
   input  logic [4:0]  regfile_write_num_mem_wb,
   input  logic [4:0]  rs_num,
   input  logic [4:0]  rt_num,
   output logic [31:0] rs_data,
   output logic [31:0] rt_data,
   input  logic [4:0]  dbg_num,
   output logic [31:0] dbg_data,
   output logic        halted,
   output logic [15:0] retired_count,
   output logic [31:0] wb_data
);

   localparam int          NREG       = 32;
   localparam int          NPORT      = 3;
   localparam logic [1:0]  JUMP_LINK  = 2'b10;
   localparam logic [15:0] COUNT_MAX  = 16'hFFFF;

   // Register storage; r0 has no storage at all so it can never be written.
   logic [31:0] regs_reg [1:NREG-1];
   // Flat read view of the file with r0 tied to zero.
   logic [31:0] rd_word  [0:NREG-1];

   logic        halted_reg;
   logic [15:0] retired_reg;
   logic        write_en;
   logic [31:0] wb_value;

   // Read ports collected so one generate loop builds all three bypass muxes.
   logic [4:0]  rd_num [0:NPORT-1];
   logic [31:0] rd_val [0:NPORT-1];

   // Writeback value select: link beats load data, load data beats ALU result.
   always_comb begin
      wb_value = alu_out_mem_wb;
      if (Jump_mem_wb == JUMP_LINK) begin
         wb_value = pc_mem_wb + 32'd4;
      end else if (MemtoReg_mem_wb) begin
         wb_value = ram_read_data_mem_wb;
      end
   end

   // A halt instruction, and everything after it, must not modify state.
   always_comb begin
      write_en = RegWrite_mem_wb && !halt_mem_wb && !halted_reg &&
                 (regfile_write_num_mem_wb != 5'd0);
   end

   assign rd_word[0] = '0;

   // One flop bank per register, each cleared asynchronously and loaded
   // when the decoded write address selects it.
   generate
      for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               regs_reg[gi] <= '0;
            end else if (write_en && (regfile_write_num_mem_wb == 5'(gi))) begin
               regs_reg[gi] <= wb_value;
            end
         end
         assign rd_word[gi] = regs_reg[gi];
      end
   endgenerate

   // Sticky halt flag: set by the first halt seen, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         halted_reg <= 1'b0;
      end else if (halt_mem_wb) begin
         halted_reg <= 1'b1;
      end
   end

   // Retired-instruction counter: counts non-bubbles before halt, saturating.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retired_reg <= '0;
      end else if ((instruction_mem_wb != 32'h0) && !halted_reg && !halt_mem_wb &&
                   (retired_reg != COUNT_MAX)) begin
         retired_reg <= retired_reg + 16'd1;
      end
   end

   assign rd_num[0] = rs_num;
   assign rd_num[1] = rt_num;
   assign rd_num[2] = dbg_num;

   // Per-port read: storage, overridden by the in-flight write to the same
   // register, overridden again by the r0-is-zero rule.
   generate
      for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
         always_comb begin
            rd_val[gi] = rd_word[rd_num[gi]];
            if (write_en && (rd_num[gi] == regfile_write_num_mem_wb)) begin
               rd_val[gi] = wb_value;
            end
            if (rd_num[gi] == 5'd0) begin
               rd_val[gi] = '0;
            end
         end
      end
   endgenerate

   assign rs_data       = rd_val[0];
   assign rt_data       = rd_val[1];
   assign dbg_data      = rd_val[2];
   assign halted        = halted_reg;
   assign retired_count = retired_reg;
   assign wb_data       = wb_value;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: expected values are queued when the
// stimulus is applied and popped when the corresponding output is sampled.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc_mem_wb;
   logic [31:0] instruction_mem_wb;
   logic        MemtoReg_mem_wb;
   logic [1:0]  Jump_mem_wb;
   logic [31:0] alu_out_mem_wb;
   logic [31:0] ram_read_data_mem_wb;
   logic        RegWrite_mem_wb;
   logic        halt_mem_wb;
   logic [4:0]  regfile_write_num_mem_wb;
   logic [4:0]  rs_num;
   logic [4:0]  rt_num;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [4:0]  dbg_num;
   logic [31:0] dbg_data;
   logic        halted;
   logic [15:0] retired_count;
   logic [31:0] wb_data;

   int checks = 0;
   int passed = 0;
   logic [31:0] exp_q [$];
   logic [31:0] exp_v;
   logic [31:0] got_v;

   wb_regfile dut (
      .clk                      (clk),
      .rst                      (rst),
      .pc_mem_wb                (pc_mem_wb),
      .instruction_mem_wb       (instruction_mem_wb),
      .MemtoReg_mem_wb          (MemtoReg_mem_wb),
      .Jump_mem_wb              (Jump_mem_wb),
      .alu_out_mem_wb           (alu_out_mem_wb),
      .ram_read_data_mem_wb     (ram_read_data_mem_wb),
      .RegWrite_mem_wb          (RegWrite_mem_wb),
      .halt_mem_wb              (halt_mem_wb),
      .regfile_write_num_mem_wb (regfile_write_num_mem_wb),
      .rs_num                   (rs_num),
      .rt_num                   (rt_num),
      .rs_data                  (rs_data),
      .rt_data                  (rt_data),
      .dbg_num                  (dbg_num),
      .dbg_data                 (dbg_data),
      .halted                   (halted),
      .retired_count            (retired_count),
      .wb_data                  (wb_data)
   );

   always #5 clk = ~clk;

   task automatic idle();
      pc_mem_wb = '0; instruction_mem_wb = '0; MemtoReg_mem_wb = 1'b0;
      Jump_mem_wb = 2'b00; alu_out_mem_wb = '0; ram_read_data_mem_wb = '0;
      RegWrite_mem_wb = 1'b0; halt_mem_wb = 1'b0; regfile_write_num_mem_wb = '0;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                        input logic m2r, input logic [1:0] jmp,
                        input logic [31:0] alu, input logic [31:0] ram,
                        input logic rw, input logic hlt, input logic [4:0] num);
      pc_mem_wb = pc; instruction_mem_wb = instr; MemtoReg_mem_wb = m2r;
      Jump_mem_wb = jmp; alu_out_mem_wb = alu; ram_read_data_mem_wb = ram;
      RegWrite_mem_wb = rw; halt_mem_wb = hlt; regfile_write_num_mem_wb = num;
   endtask

   // Advance to just after the next active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse reset between edges and leave inputs idle.
   task automatic reset_pulse();
      @(negedge clk);
      idle();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      idle();
      rs_num = 5'd0; rt_num = 5'd0; dbg_num = 5'd0;
      rst = 1'b1;
      #3;
      exp_q.push_back(32'h0);
      #1; exp_v = exp_q.pop_front(); got_v = {31'h0, halted};
      checks++;
      if (got_v !== exp_v) $display("FAIL reset_halted got=%h exp=%h", got_v, exp_v);
      else passed++;
      exp_q.push_back(32'h0);
      exp_v = exp_q.pop_front(); got_v = {16'h0, retired_count};
      checks++;
      if (got_v !== exp_v) $display("FAIL reset_count got=%h exp=%h", got_v, exp_v);
      else passed++;
      // Write attempt across an edge while reset is held must be discarded.
      drive(32'h0, 32'h1, 1'b0, 2'b00, 32'h22, 32'h0, 1'b1, 1'b0, 5'd2);
      tick();
      @(negedge clk);
      idle();
      rst = 1'b0;
      dbg_num = 5'd2;
      exp_q.push_back(32'h0);
      #1; exp_v = exp_q.pop_front(); got_v = dbg_data;
      checks++;
      if (got_v !== exp_v) $display("FAIL reset_edge_write got=%h exp=%h", got_v, exp_v);
      else passed++;
      exp_q.push_back(32'h0);
      exp_v = exp_q.pop_front(); got_v = {16'h0, retired_count};
      checks++;
      if (got_v !== exp_v) $display("FAIL reset_edge_count got=%h exp=%h", got_v, exp_v);
      else passed++;
      tick();
   endtask

   task automatic test_bypass();
      drive(32'h0, 32'h1, 1'b0, 2'b00, 32'h1234, 32'h0, 1'b1, 1'b0, 5'd5);
      rs_num = 5'd5;
      exp_q.push_back(32'h1234);
      #1; exp_v = exp_q.pop_front(); got_v = rs_data;
      checks++;
      if (got_v !== exp_v) $display("FAIL bypass_rs got=%h exp=%h", got_v, exp_v);
      else passed++;
      tick();
      idle();
      exp_q.push_back(32'h1234);
      #1; exp_v = exp_q.pop_front(); got_v = rs_data;
      checks++;
      if (got_v !== exp_v) $display("FAIL stored_rs got=%h exp=%h", got_v, exp_v);
      else passed++;
   endtask

   task automatic test_link();
      drive(32'h0000_0040, 32'h1, 1'b1, 2'b10, 32'h55, 32'h66, 1'b1, 1'b0, 5'd31);
      exp_q.push_back(32'h0000_0044);
      #1; exp_v = exp_q.pop_front(); got_v = wb_data;
      checks++;
      if (got_v !== exp_v) $display("FAIL link_wb_data got=%h exp=%h", got_v, exp_v);
      else passed++;
      tick();
      idle();
      dbg_num = 5'd31;
      exp_q.push_back(32'h0000_0044);
      #1; exp_v = exp_q.pop_front(); got_v = dbg_data;
      checks++;
      if (got_v !== exp_v) $display("FAIL link_reg31 got=%h exp=%h", got_v, exp_v);
      else passed++;
      drive(32'hFFFF_FFFC, 32'h1, 1'b0, 2'b10, 32'h55, 32'h66, 1'b1, 1'b0, 5'd31);
      tick();
      idle();
      exp_q.push_back(32'h0);
      #1; exp_v = exp_q.pop_front(); got_v = dbg_data;
      checks++;
      if (got_v !== exp_v) $display("FAIL link_wrap got=%h exp=%h", got_v, exp_v);
      else passed++;
   endtask

   task automatic test_select();
      // Load data selected when not linking.
      drive(32'h100, 32'h1, 1'b1, 2'b00, 32'hBEEF, 32'hCAFE, 1'b1, 1'b0, 5'd6);
      exp_q.push_back(32'hCAFE);
      #1; exp_v = exp_q.pop_front(); got_v = wb_data;
      checks++;
      if (got_v !== exp_v) $display("FAIL sel_mem got=%h exp=%h", got_v, exp_v);
      else passed++;
      tick();
      idle();
      rt_num = 5'd6;
      exp_q.push_back(32'hCAFE);
      #1; exp_v = exp_q.pop_front(); got_v = rt_data;
      checks++;
      if (got_v !== exp_v) $display("FAIL sel_mem_reg6 got=%h exp=%h", got_v, exp_v);
      else passed++;
      // A non-link jump class does not select the PC.
      drive(32'h100, 32'h1, 1'b0, 2'b01, 32'hBEEF, 32'hCAFE, 1'b1, 1'b0, 5'd6);
      exp_q.push_back(32'hBEEF);
      #1; exp_v = exp_q.pop_front(); got_v = wb_data;
      checks++;
      if (got_v !== exp_v) $display("FAIL sel_alu got=%h exp=%h", got_v, exp_v);
      else passed++;
      tick();
      idle();
   endtask

   task automatic test_r0();
      drive(32'h0, 32'h1, 1'b0, 2'b00, 32'hDEAD, 32'h0, 1'b1, 1'b0, 5'd0);
      dbg_num = 5'd0; rs_num = 5'd0;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      #1; exp_v = exp_q.pop_front(); got_v = dbg_data;
      checks++;
      if (got_v !== exp_v) $display("FAIL r0_dbg_before got=%h exp=%h", got_v, exp_v);
      else passed++;
      exp_v = exp_q.pop_front(); got_v = rs_data;
      checks++;
      if (got_v !== exp_v) $display("FAIL r0_rs_before got=%h exp=%h", got_v, exp_v);
      else passed++;
      tick();
      idle();
      exp_q.push_back(32'h0);
      #1; exp_v = exp_q.pop_front(); got_v = dbg_data;
      checks++;
      if (got_v !== exp_v) $display("FAIL r0_dbg_after got=%h exp=%h", got_v, exp_v);
      else passed++;
   endtask

   task automatic test_ports();
      drive(32'h0, 32'h1, 1'b0, 2'b00, 32'h88, 32'h0, 1'b1, 1'b0, 5'd8);
      tick();
      drive(32'h0, 32'h1, 1'b0, 2'b00, 32'h99, 32'h0, 1'b1, 1'b0, 5'd9);
      tick();
      // Bypass must hit only the ports addressing the register being written.
      drive(32'h0, 32'h1, 1'b0, 2'b00, 32'h999, 32'h0, 1'b1, 1'b0, 5'd9);
      rs_num = 5'd8; rt_num = 5'd9; dbg_num = 5'd9;
      exp_q.push_back(32'h88);
      exp_q.push_back(32'h999);
      exp_q.push_back(32'h999);
      #1; exp_v = exp_q.pop_front(); got_v = rs_data;
      checks++;
      if (got_v !== exp_v) $display("FAIL port_rs_nobypass got=%h exp=%h", got_v, exp_v);
      else passed++;
      exp_v = exp_q.pop_front(); got_v = rt_data;
      checks++;
      if (got_v !== exp_v) $display("FAIL port_rt_bypass got=%h exp=%h", got_v, exp_v);
      else passed++;
      exp_v = exp_q.pop_front(); got_v = dbg_data;
      checks++;
      if (got_v !== exp_v) $display("FAIL port_dbg_bypass got=%h exp=%h", got_v, exp_v);
      else passed++;
      // Without RegWrite there is no bypass: storage value is returned.
      RegWrite_mem_wb = 1'b0;
      exp_q.push_back(32'h99);
      #1; exp_v = exp_q.pop_front(); got_v = rt_data;
      checks++;
      if (got_v !== exp_v) $display("FAIL port_no_we got=%h exp=%h", got_v, exp_v);
      else passed++;
      idle();
      tick();
   endtask

   task automatic test_retire();
      reset_pulse();
      // Five non-bubbles (one without RegWrite) interleaved with bubbles.
      for (int i = 0; i < 5; i++) begin
         drive(32'h0, 32'h20 + 32'(i), 1'b0, 2'b00, 32'h0, 32'h0, (i != 2), 1'b0, 5'd10);
         tick();
         idle();
         tick();
      end
      exp_q.push_back(32'd5);
      exp_v = exp_q.pop_front(); got_v = {16'h0, retired_count};
      checks++;
      if (got_v !== exp_v) $display("FAIL retire_count got=%h exp=%h", got_v, exp_v);
      else passed++;
   endtask

   task automatic test_halt();
      reset_pulse();
      drive(32'h0, 32'h1, 1'b0, 2'b00, 32'h9, 32'h0, 1'b1, 1'b0, 5'd7);
      tick();
      drive(32'h0, 32'h1, 1'b0, 2'b00, 32'h1, 32'h0, 1'b1, 1'b0, 5'd3);
      tick();
      drive(32'h0, 32'h1, 1'b0, 2'b00, 32'h7, 32'h0, 1'b1, 1'b1, 5'd3);
      dbg_num = 5'd3;
      exp_q.push_back(32'h1);
      #1; exp_v = exp_q.pop_front(); got_v = dbg_data;
      checks++;
      if (got_v !== exp_v) $display("FAIL halt_no_bypass got=%h exp=%h", got_v, exp_v);
      else passed++;
      tick();
      drive(32'h0, 32'h1, 1'b0, 2'b00, 32'h44, 32'h0, 1'b1, 1'b0, 5'd4);
      exp_q.push_back(32'h1);
      exp_q.push_back(32'h1);
      exp_q.push_back(32'h0);
      #1; exp_v = exp_q.pop_front(); got_v = {31'h0, halted};
      checks++;
      if (got_v !== exp_v) $display("FAIL halt_flag got=%h exp=%h", got_v, exp_v);
      else passed++;
      exp_v = exp_q.pop_front(); got_v = dbg_data;
      checks++;
      if (got_v !== exp_v) $display("FAIL halt_reg3 got=%h exp=%h", got_v, exp_v);
      else passed++;
      dbg_num = 5'd4;
      #1; exp_v = exp_q.pop_front(); got_v = dbg_data;
      checks++;
      if (got_v !== exp_v) $display("FAIL halt_post_bypass got=%h exp=%h", got_v, exp_v);
      else passed++;
      tick();
      tick();
      idle();
      exp_q.push_back(32'h0);
      exp_q.push_back(32'd2);
      exp_q.push_back(32'h1);
      #1; exp_v = exp_q.pop_front(); got_v = dbg_data;
      checks++;
      if (got_v !== exp_v) $display("FAIL halt_post_write got=%h exp=%h", got_v, exp_v);
      else passed++;
      exp_v = exp_q.pop_front(); got_v = {16'h0, retired_count};
      checks++;
      if (got_v !== exp_v) $display("FAIL halt_count got=%h exp=%h", got_v, exp_v);
      else passed++;
      exp_v = exp_q.pop_front(); got_v = {31'h0, halted};
      checks++;
      if (got_v !== exp_v) $display("FAIL halt_sticky got=%h exp=%h", got_v, exp_v);
      else passed++;
   endtask

   task automatic test_async_reset();
      // Continues from the halted state left by test_halt (reg7 = 9).
      @(negedge clk);
      dbg_num = 5'd7;
      exp_q.push_back(32'h9);
      #1; exp_v = exp_q.pop_front(); got_v = dbg_data;
      checks++;
      if (got_v !== exp_v) $display("FAIL areset_pre_reg7 got=%h exp=%h", got_v, exp_v);
      else passed++;
      rst = 1'b1;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      #1; exp_v = exp_q.pop_front(); got_v = {31'h0, halted};
      checks++;
      if (got_v !== exp_v) $display("FAIL areset_halted got=%h exp=%h", got_v, exp_v);
      else passed++;
      exp_v = exp_q.pop_front(); got_v = dbg_data;
      checks++;
      if (got_v !== exp_v) $display("FAIL areset_reg7 got=%h exp=%h", got_v, exp_v);
      else passed++;
      exp_v = exp_q.pop_front(); got_v = {16'h0, retired_count};
      checks++;
      if (got_v !== exp_v) $display("FAIL areset_count got=%h exp=%h", got_v, exp_v);
      else passed++;
      rst = 1'b0;
      drive(32'h0, 32'h1, 1'b0, 2'b00, 32'h5, 32'h0, 1'b1, 1'b0, 5'd7);
      tick();
      idle();
      exp_q.push_back(32'h5);
      exp_q.push_back(32'd1);
      #1; exp_v = exp_q.pop_front(); got_v = dbg_data;
      checks++;
      if (got_v !== exp_v) $display("FAIL areset_resume_reg7 got=%h exp=%h", got_v, exp_v);
      else passed++;
      exp_v = exp_q.pop_front(); got_v = {16'h0, retired_count};
      checks++;
      if (got_v !== exp_v) $display("FAIL areset_resume_count got=%h exp=%h", got_v, exp_v);
      else passed++;
   endtask

   task automatic test_saturate();
      reset_pulse();
      drive(32'h0, 32'h1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
      repeat (65534) tick();
      exp_q.push_back(32'h0000_FFFE);
      exp_v = exp_q.pop_front(); got_v = {16'h0, retired_count};
      checks++;
      if (got_v !== exp_v) $display("FAIL sat_fffe got=%h exp=%h", got_v, exp_v);
      else passed++;
      tick();
      exp_q.push_back(32'h0000_FFFF);
      exp_v = exp_q.pop_front(); got_v = {16'h0, retired_count};
      checks++;
      if (got_v !== exp_v) $display("FAIL sat_ffff got=%h exp=%h", got_v, exp_v);
      else passed++;
      repeat (5) tick();
      exp_q.push_back(32'h0000_FFFF);
      exp_v = exp_q.pop_front(); got_v = {16'h0, retired_count};
      checks++;
      if (got_v !== exp_v) $display("FAIL sat_nowrap got=%h exp=%h", got_v, exp_v);
      else passed++;
      idle();
      repeat (3) tick();
      exp_q.push_back(32'h0000_FFFF);
      exp_v = exp_q.pop_front(); got_v = {16'h0, retired_count};
      checks++;
      if (got_v !== exp_v) $display("FAIL sat_bubble got=%h exp=%h", got_v, exp_v);
      else passed++;
   endtask

   initial begin
      idle();
      rs_num = '0; rt_num = '0; dbg_num = '0;
      test_reset();
      test_bypass();
      test_link();
      test_select();
      test_r0();
      test_ports();
      test_retire();
      test_halt();
      test_async_reset();
      test_saturate();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-003 SHALL have port pc_mem_wb, input, 32, PC of the instruction in writeback.
REQ-004 SHALL have port instruction_mem_wb, input, 32, instruction word in writeback; 32'h0 means bubble.
REQ-005 SHALL have port MemtoReg_mem_wb, input, 1, selects RAM read data as write data.
REQ-006 SHALL have port Jump_mem_wb, input, 2, jump class; 2'b10 means link (JAL).
REQ-007 SHALL have port alu_out_mem_wb, input, 32, ALU result.
REQ-008 SHALL have port ram_read_data_mem_wb, input, 32, load data.
REQ-009 SHALL have port RegWrite_mem_wb, input, 1, register write enable.
REQ-010 SHALL have port halt_mem_wb, input, 1, halt instruction in writeback.
REQ-011 SHALL have port regfile_write_num_mem_wb, input, 5, destination register number.
REQ-012 SHALL have ports rs_num and rt_num, input, 5 each, decode-stage read addresses.
REQ-013 SHALL have ports rs_data and rt_data, output, 32 each, read data.
REQ-014 SHALL have port dbg_num, input, 5, debug read address; dbg_data, output, 32, debug read data.
REQ-015 SHALL have port halted, output, 1, sticky halt flag.
REQ-016 SHALL have port retired_count, output, 16, count of retired non-bubble instructions.
REQ-017 SHALL have port wb_data, output, 32, selected writeback value (combinational).

Function
REQ-018 SHALL hold 32 registers of 32 bits; register 0 SHALL always read 0 and never be written.
REQ-019 SHALL select wb_data with priority: link (Jump_mem_wb==2'b10) -> pc_mem_wb+4 (mod 2^32); else MemtoReg_mem_wb=1 -> ram_read_data_mem_wb; else alu_out_mem_wb.
REQ-020 SHALL set the write enable to RegWrite_mem_wb AND NOT halt_mem_wb AND NOT halted AND regfile_write_num_mem_wb!=0.
REQ-021 SHALL write wb_data to regfile_write_num_mem_wb on the rising clk edge when the write enable is 1.
REQ-022 SHALL produce rs_data, rt_data and dbg_data combinationally, with zero-cycle latency.
REQ-023 SHALL bypass write data to a read: when the write enable is 1 and the read address equals regfile_write_num_mem_wb, the read port SHALL return wb_data in the same cycle.
REQ-024 SHALL apply the bypass of REQ-023 independently to rs, rt and dbg ports.
REQ-025 SHALL return 0 for every read port addressing register 0, regardless of bypass.
REQ-026 SHALL set halted to 1 on the first rising edge where halt_mem_wb=1; halted SHALL stay 1 until reset.
REQ-027 SHALL block all register writes from the halt instruction itself and from every cycle after it.
REQ-028 SHALL increment retired_count by 1 on each rising edge where instruction_mem_wb!=0, halted=0 and halt_mem_wb=0.
REQ-029 SHALL saturate retired_count at 16'hFFFF; it SHALL NOT wrap.
REQ-030 SHALL suppress the write for a bubble, because a bubble arrives with RegWrite_mem_wb=0.

Reset
REQ-031 SHALL, while rst=1, clear all 32 registers to 0, halted to 0 and retired_count to 0 immediately, independent of clk.
REQ-032 SHALL block register writes and counter updates while rst=1, including on a coincident clock edge.
REQ-033 SHALL, after rst falls, resume normal operation on the next rising clk edge.
REQ-034 SHALL clear a set halted flag when rst is asserted mid-run.

Verification
REQ-035 SHALL cover this case: RegWrite=1, num=5, MemtoReg=0, alu_out=32'h1234, rs_num=5 in the same cycle -> rs_data=32'h1234 (bypass); after the edge, rs_data=32'h1234 from storage.
REQ-036 SHALL cover this case: Jump=2'b10, pc=32'h0000_0040, num=31, RegWrite=1, MemtoReg=1 -> reg31=32'h0000_0044 (link overrides MemtoReg); PC 32'hFFFF_FFFC -> reg31=32'h0.
REQ-037 SHALL cover this case: RegWrite=1, num=0, alu_out=32'hDEAD -> dbg_num=0 reads 0 both before and after the edge.
REQ-038 SHALL cover this case: halt_mem_wb=1 with RegWrite=1, num=3, alu_out=7 -> reg3 unchanged and halted=1; later writes are ignored; retired_count stops.
REQ-039 SHALL cover this case: 70000 non-bubble retires -> retired_count=16'hFFFF; bubble cycles leave the count unchanged.
REQ-040 SHALL cover this case: rst pulsed between clock edges while halted=1 and reg7=9 -> halted=0, reg7=0 and retired_count=0 immediately.
